// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-and-accumulate multiplier.
package mult_pkg;

    // Widest value the negate helper handles; products up to 2*64 bits.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles for one product.
    function automatic int calc_n(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Counter width able to hold 0..N.
    function automatic int calc_cnt_w(input int width, input int bpc);
        return $clog2(width / bpc + 1);
    endfunction

    // Two's-complement negate; callers zero-extend into MAX_W and truncate back.
    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
        return ~v + 1'b1;
    endfunction

endpackage

// File: rtl/mult_magnitude.sv
// Operand conditioning: turns a WIDTH-bit operand into an unsigned magnitude
// plus a sign flag. -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits WIDTH bits.
module mult_magnitude
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             neg_o
);

    // Negate only signed operands with the MSB set.
    always_comb begin
        neg_o = signed_i & value_i[WIDTH-1];
        mag_o = value_i;
        if (neg_o) begin
            mag_o = WIDTH'(twos_neg(MAX_W'(value_i)));
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-accumulate multiplier. Retires BITS_PER_CYCLE multiplier
// bits per RUN cycle; result appears N+1 cycles after the accepting cycle.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// holds its bundle until that edge; ready never depends on the same-side valid.
// WIDTH must be >= 4 and <= 64, and BITS_PER_CYCLE must divide WIDTH.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               sign,
    output state_t             dbg_state
);

    localparam int N  = calc_n(WIDTH, BITS_PER_CYCLE);
    localparam int CW = calc_cnt_w(WIDTH, BITS_PER_CYCLE);
    localparam int AW = 2 * WIDTH;
    // Running top half plus one step of partial products never exceeds this.
    localparam int PW = WIDTH + BITS_PER_CYCLE;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  mul_q, mul_d;
    logic [WIDTH-1:0]  mag_a_q, mag_a_d;
    logic              neg_q, neg_d;
    logic [AW-1:0]     result_q, result_d;
    logic              sign_q, sign_d;

    logic [WIDTH-1:0]  mag_a, mag_b;
    logic              neg_a, neg_b;
    logic [PW-1:0]     partial, sum;
    logic [AW+BITS_PER_CYCLE-1:0] wide;
    logic [AW-1:0]     acc_step;

    mult_magnitude #(.WIDTH(WIDTH)) u_mag_a (
        .value_i  (a),
        .signed_i (in_signed),
        .mag_o    (mag_a),
        .neg_o    (neg_a)
    );

    mult_magnitude #(.WIDTH(WIDTH)) u_mag_b (
        .value_i  (b),
        .signed_i (in_signed),
        .mag_o    (mag_b),
        .neg_o    (neg_b)
    );

    // One datapath step: add selected shifted multiplicands into the top half, then shift right.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mul_q[j]) begin
                partial = partial + (PW'(mag_a_q) << j);
            end
        end
        sum      = PW'(acc_q[AW-1:WIDTH]) + partial;
        wide     = {sum, acc_q[WIDTH-1:0]};
        acc_step = AW'(wide >> BITS_PER_CYCLE);
    end

    // Next-state and register updates for IDLE -> RUN -> DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mul_d    = mul_q;
        mag_a_d  = mag_a_q;
        neg_d    = neg_q;
        result_d = result_q;
        sign_d   = sign_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_a_d = mag_a;
                    mul_d   = mag_b;
                    neg_d   = neg_a ^ neg_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                mul_d = mul_q >> BITS_PER_CYCLE;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    result_d = neg_q ? AW'(twos_neg(MAX_W'(acc_step))) : acc_step;
                    sign_d   = neg_q & (acc_step != '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset discarding any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mul_q    <= '0;
            mag_a_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mul_q    <= mul_d;
            mag_a_q  <= mag_a_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            sign_q   <= sign_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign sign      = sign_q;
    assign dbg_state = state_q;

endmodule
